// File: rtl/garegga_sound_pkg.sv
// Shared definitions for the Garegga sound-command mailbox: FSM state
// encoding, Z80-side mailbox addresses and default handshake timings.
package garegga_sound_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_PULSE    = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_GAP      = 3'd4
  } sndcmd_state_e;

  // Z80 address map: read soundlatch / write-to-ack
  localparam logic [15:0] Z80_SOUNDLATCH_ADDR = 16'hE01C;
  localparam logic [15:0] Z80_ACK_ADDR        = 16'hE00C;

  localparam int unsigned DEF_INT_PULSE_LEN = 8;
  localparam int unsigned DEF_MIN_GAP       = 16;

endpackage

// File: rtl/garegga_sndcmd_fifo.sv
// Synchronous FIFO for 68k sound commands. Head data is presented
// combinationally and is valid whenever the FIFO is not empty.
module garegga_sndcmd_fifo #(
  parameter int unsigned AW = 2,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic [AW:0]   count_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int unsigned  DEPTH   = 1 << AW;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // a pop frees a slot in the same cycle, so a full FIFO still accepts a push
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  // Next pointer/count; flush overrides any push or pop
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_ONE;
      if (do_pop)  rptr_d = rptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
      else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/garegga_sndcmd_tx.sv
// 68k-side sound-command initiator: queues command bytes, presents each on
// SOUNDLATCH with a Z80INT pulse and waits for the Z80 ack before the next.
// Optional ack watchdog enabled by defining GAREGGA_SNDCMD_TIMEOUT_EN.
module garegga_sndcmd_tx
  import garegga_sound_pkg::*;
#(
  parameter int unsigned FIFO_AW       = 2,
  parameter int unsigned INT_PULSE_LEN = DEF_INT_PULSE_LEN,
  parameter int unsigned MIN_GAP       = DEF_MIN_GAP
`ifdef GAREGGA_SNDCMD_TIMEOUT_EN
  ,
  parameter int unsigned ACK_TIMEOUT   = 1048576
`endif
) (
  input  logic       CLK96,
  input  logic       RESET96_N,
  input  logic       CMD_WE,
  input  logic [7:0] CMD_DATA,
  input  logic       FLUSH,
  input  logic       CLR_ERR,
  output logic       CMD_FULL,
  output logic       BUSY,
  output logic       OVERFLOW,
  output logic       TIMEOUT,
  output logic [7:0] SOUNDLATCH,
  output logic       Z80INT,
  input  logic       Z80_ACK
);

  localparam int unsigned CNT_MAX = (INT_PULSE_LEN > MIN_GAP) ? INT_PULSE_LEN : MIN_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(INT_PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(MIN_GAP - 1);

  sndcmd_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acked_q, acked_d;
  logic [7:0]       latch_q, latch_d;
  logic             int_q, int_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;

  logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [7:0]       fifo_head;
  logic [FIFO_AW:0] fifo_count;
  logic             wd_fire;

  garegga_sndcmd_fifo #(
    .AW (FIFO_AW),
    .DW (8)
  ) u_fifo (
    .clk_i   (CLK96),
    .rst_ni  (RESET96_N),
    .flush_i (FLUSH),
    .push_i  (fifo_push),
    .wdata_i (CMD_DATA),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign fifo_push = CMD_WE & ~FLUSH & (~fifo_full | fifo_pop);

`ifdef GAREGGA_SNDCMD_TIMEOUT_EN
  localparam logic [19:0] WD_LAST = 20'(ACK_TIMEOUT - 1);

  logic [19:0] wd_q, wd_d;
  logic        to_q, to_d;

  assign wd_fire = (wd_q == WD_LAST);
  assign TIMEOUT = to_q;

  // Ack watchdog: restarts per command, counts only while waiting for the ack
  always_comb begin
    wd_d = wd_q;
    if (state_q == S_LOAD)          wd_d = '0;
    else if (state_q == S_WAIT_ACK) wd_d = wd_q + 20'd1;
    to_d = (to_q & ~CLR_ERR) |
           ((state_q == S_WAIT_ACK) & ~Z80_ACK & wd_fire & ~FLUSH);
  end

  // Watchdog counter and sticky timeout flag
  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign TIMEOUT = 1'b0;
`endif

  // Handshake FSM next-state and output logic; FLUSH overrides everything
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acked_d  = acked_q;
    latch_d  = latch_q;
    int_d    = int_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) state_d = S_LOAD;
      end
      S_LOAD: begin
        fifo_pop = 1'b1;
        latch_d  = fifo_head;
        int_d    = 1'b1;
        cnt_d    = '0;
        acked_d  = 1'b0;
        state_d  = S_PULSE;
      end
      S_PULSE: begin
        cnt_d = cnt_q + CNT_ONE;
        if (Z80_ACK) acked_d = 1'b1;
        if (cnt_q == PULSE_LAST) begin
          int_d   = 1'b0;
          cnt_d   = '0;
          state_d = (acked_q | Z80_ACK) ? S_GAP : S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (Z80_ACK || wd_fire) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (FLUSH) begin
      state_d  = S_IDLE;
      int_d    = 1'b0;
      cnt_d    = '0;
      fifo_pop = 1'b0;
    end
  end

  // Registered flags; BUSY is derived from next state so it tracks the FSM without lag
  always_comb begin
    busy_d = (state_d != S_IDLE) | fifo_push | (~FLUSH & (fifo_count != '0));
    ovf_d  = (ovf_q & ~CLR_ERR) | (CMD_WE & ~FLUSH & fifo_full & ~fifo_pop);
  end

  // FSM, counter, latch and flag registers
  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acked_q <= 1'b0;
      latch_q <= '0;
      int_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acked_q <= acked_d;
      latch_q <= latch_d;
      int_q   <= int_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign SOUNDLATCH = latch_q;
  assign Z80INT     = int_q;
  assign BUSY       = busy_q;
  assign OVERFLOW   = ovf_q;
  assign CMD_FULL   = fifo_full;

endmodule

// File: tb/tb_garegga_sndcmd_tx.sv
// Bench for garegga_sndcmd_tx: directed stimulus, expected command bytes
// queued in a scoreboard and checked on every Z80INT rising edge.
// Watchdog checks run when GAREGGA_SNDCMD_TIMEOUT_EN is defined.
module tb_garegga_sndcmd_tx;

  logic       CLK96 = 1'b0;
  logic       RESET96_N = 1'b0;
  logic       CMD_WE = 1'b0;
  logic [7:0] CMD_DATA = '0;
  logic       FLUSH = 1'b0;
  logic       CLR_ERR = 1'b0;
  logic       Z80_ACK = 1'b0;
  logic       CMD_FULL, BUSY, OVERFLOW, TIMEOUT, Z80INT;
  logic [7:0] SOUNDLATCH;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb[$];
  logic int_prev = 1'b0;

  always #5 CLK96 = ~CLK96;

`ifdef GAREGGA_SNDCMD_TIMEOUT_EN
  garegga_sndcmd_tx #(.ACK_TIMEOUT(64)) dut (
`else
  garegga_sndcmd_tx dut (
`endif
    .CLK96      (CLK96),
    .RESET96_N  (RESET96_N),
    .CMD_WE     (CMD_WE),
    .CMD_DATA   (CMD_DATA),
    .FLUSH      (FLUSH),
    .CLR_ERR    (CLR_ERR),
    .CMD_FULL   (CMD_FULL),
    .BUSY       (BUSY),
    .OVERFLOW   (OVERFLOW),
    .TIMEOUT    (TIMEOUT),
    .SOUNDLATCH (SOUNDLATCH),
    .Z80INT     (Z80INT),
    .Z80_ACK    (Z80_ACK)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each Z80INT rising edge must present the next expected byte
  always @(negedge CLK96) begin
    if (Z80INT === 1'b1 && int_prev === 1'b0) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_int: got SOUNDLATCH=%0h, expected no command", SOUNDLATCH);
      end else begin
        chk("latch_order", SOUNDLATCH, sb.pop_front());
      end
    end
    int_prev <= Z80INT;
  end

  task automatic wr(input logic [7:0] d);
    CMD_DATA = d;
    CMD_WE   = 1'b1;
    @(posedge CLK96); #1;
    CMD_WE   = 1'b0;
  endtask

  task automatic ack();
    @(posedge CLK96); #1;
    Z80_ACK = 1'b1;
    @(posedge CLK96); #1;
    Z80_ACK = 1'b0;
  endtask

  // Steps negedges until Z80INT reaches lvl or maxc steps pass
  task automatic wait_int(input logic lvl, input int maxc, output int n);
    n = 0;
    while (Z80INT !== lvl && n < maxc) begin
      @(negedge CLK96);
      n++;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (BUSY !== 1'b0 && n < 200) begin
      @(negedge CLK96);
      n++;
    end
    chk(name, BUSY, 1'b0);
  endtask

  task automatic ack_next(input string name);
    int n;
    wait_int(1'b1, 60, n);
    chk({name, "_hi"}, Z80INT, 1'b1);
    wait_int(1'b0, 60, n);
    chk({name, "_lo"}, Z80INT, 1'b0);
    ack();
  endtask

  initial begin
    #200us;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;

    // Reset values
    repeat (3) @(posedge CLK96);
    #1;
    chk("rst_latch", SOUNDLATCH, 8'h00);
    chk("rst_int", Z80INT, 1'b0);
    chk("rst_full", CMD_FULL, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_ovf", OVERFLOW, 1'b0);
    chk("rst_to", TIMEOUT, 1'b0);
    RESET96_N = 1'b1;
    @(posedge CLK96); #1;

    // Single command: latency, pulse width, hold until ack, gap length
    sb.push_back(8'h5A);
    wr(8'h5A);
    @(negedge CLK96);
    chk("t1_busy_n", BUSY, 1'b1);
    chk("t1_int_n", Z80INT, 1'b0);
    @(negedge CLK96);
    chk("t1_int_n1", Z80INT, 1'b0);
    @(negedge CLK96);
    chk("t1_int_n2", Z80INT, 1'b1);
    chk("t1_latch_n2", SOUNDLATCH, 8'h5A);
    wait_int(1'b0, 50, n);
    chk("t1_pulse_len", n, 8);
    repeat (10) @(negedge CLK96);
    chk("t1_wait_busy", BUSY, 1'b1);
    chk("t1_wait_latch", SOUNDLATCH, 8'h5A);
    ack();
    n = 0;
    forever begin
      @(negedge CLK96);
      if (BUSY !== 1'b1 || n >= 100) break;
      n++;
    end
    chk("t1_gap_len", n, 16);
    ack();
    repeat (3) @(negedge CLK96);
    chk("t1_idle_ack_ignored", BUSY, 1'b0);

    // Back-to-back writes, full FIFO, overflow, push+pop while full
    @(posedge CLK96); #1;
    for (int i = 1; i <= 5; i++) begin
      sb.push_back(8'(i));
      wr(8'(i));
    end
    @(negedge CLK96);
    chk("t2_full", CMD_FULL, 1'b1);
    chk("t2_no_ovf", OVERFLOW, 1'b0);
    wr(8'h06);
    @(negedge CLK96);
    chk("t2_ovf_set", OVERFLOW, 1'b1);
    chk("t2_still_full", CMD_FULL, 1'b1);
    CLR_ERR = 1'b1;
    @(posedge CLK96); #1;
    CLR_ERR = 1'b0;
    @(negedge CLK96);
    chk("t2_ovf_clr", OVERFLOW, 1'b0);
    wait_int(1'b0, 50, n);
    chk("t2_c1_lo", Z80INT, 1'b0);
    ack();
    // ack at edge a: GAP 16 cycles, IDLE, then LOAD pops at edge a+18
    repeat (17) @(posedge CLK96);
    #1;
    sb.push_back(8'h07);
    wr(8'h07);
    @(negedge CLK96);
    chk("t2_pushpop_no_ovf", OVERFLOW, 1'b0);
    chk("t2_pushpop_full", CMD_FULL, 1'b1);
    for (int i = 0; i < 5; i++) ack_next("t2_ack");
    wait_idle("t2_drain_idle");

    // Ack during PULSE skips WAIT_ACK; the latched ack must not carry over
    @(posedge CLK96); #1;
    sb.push_back(8'hA1);
    wr(8'hA1);
    sb.push_back(8'hA2);
    wr(8'hA2);
    wait_int(1'b1, 20, n);
    ack();
    wait_int(1'b0, 20, n);
    chk("t3_a1_lo", Z80INT, 1'b0);
    wait_int(1'b1, 50, n);
    chk("t3_fall_to_rise", n, 18);
    wait_int(1'b0, 20, n);
    repeat (30) @(negedge CLK96);
    chk("t3_a2_waits", BUSY, 1'b1);
    ack();
    wait_idle("t3_idle");

    // FLUSH in WAIT_ACK with 3 queued, simultaneous write dropped
    @(posedge CLK96); #1;
    sb.push_back(8'hB1);
    wr(8'hB1);
    wait_int(1'b1, 20, n);
    wait_int(1'b0, 20, n);
    @(posedge CLK96); #1;
    wr(8'hB2);
    wr(8'hB3);
    wr(8'hB4);
    FLUSH    = 1'b1;
    CMD_WE   = 1'b1;
    CMD_DATA = 8'hEE;
    @(posedge CLK96); #1;
    FLUSH  = 1'b0;
    CMD_WE = 1'b0;
    @(negedge CLK96);
    chk("t4_int", Z80INT, 1'b0);
    chk("t4_busy", BUSY, 1'b0);
    chk("t4_full", CMD_FULL, 1'b0);
    chk("t4_latch_kept", SOUNDLATCH, 8'hB1);
    chk("t4_no_ovf", OVERFLOW, 1'b0);
    ack();
    repeat (40) @(negedge CLK96);
    chk("t4_busy_after_ack", BUSY, 1'b0);
    chk("t4_latch_after_ack", SOUNDLATCH, 8'hB1);

`ifdef GAREGGA_SNDCMD_TIMEOUT_EN
    // Watchdog completes an unacked command after 64 WAIT_ACK cycles
    @(posedge CLK96); #1;
    sb.push_back(8'hD1);
    wr(8'hD1);
    sb.push_back(8'hD2);
    wr(8'hD2);
    wait_int(1'b1, 20, n);
    wait_int(1'b0, 20, n);
    repeat (63) @(negedge CLK96);
    chk("t5_to_before", TIMEOUT, 1'b0);
    @(negedge CLK96);
    chk("t5_to_set", TIMEOUT, 1'b1);
    wait_int(1'b1, 40, n);
    chk("t5_next_cmd", Z80INT, 1'b1);
    CLR_ERR = 1'b1;
    @(posedge CLK96); #1;
    CLR_ERR = 1'b0;
    @(negedge CLK96);
    chk("t5_to_clr", TIMEOUT, 1'b0);
    wait_int(1'b0, 20, n);
    ack();
    wait_idle("t5_idle");
`endif

    // Async reset during PULSE
    @(posedge CLK96); #1;
    sb.push_back(8'hC5);
    wr(8'hC5);
    wait_int(1'b1, 20, n);
    @(posedge CLK96);
    #3;
    RESET96_N = 1'b0;
    #1;
    chk("t6_int_immediate", Z80INT, 1'b0);
    chk("t6_latch", SOUNDLATCH, 8'h00);
    chk("t6_busy", BUSY, 1'b0);
    chk("t6_full", CMD_FULL, 1'b0);
    chk("t6_ovf", OVERFLOW, 1'b0);
    chk("t6_to", TIMEOUT, 1'b0);
    @(posedge CLK96); #1;
    RESET96_N = 1'b1;
    repeat (10) @(negedge CLK96);
    chk("t6_stays_idle", BUSY, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
